// File: rtl/dmem_ctrl.sv
// Data-memory stage: executes LDUR/STUR against a word-organized memory with a
// fixed multi-cycle latency, stalling the datapath and flagging illegal accesses.
module dmem_ctrl #(
    parameter int N       = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [N-1:0] address,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    output logic         memBusy,
    output logic         memError
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [N-1:0] DEPTH_N = N'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            op_write_reg;
    logic [IW-1:0]   idx_reg;
    logic [N-1:0]    wdata_reg;
    logic [N-1:0]    read_data_reg;
    logic            mem_error_reg;

    logic            req;
    logic            in_range;
    logic            legal;
    logic            mem_we;
    logic [N-1:0]    mem_rd [DEPTH];

    assign req      = memRead | memWrite;
    assign in_range = {3'b000, address[N-1:3]} < DEPTH_N;
    assign legal    = (memRead ^ memWrite) && (address[2:0] == 3'b000) && in_range;
    assign mem_we   = (state_reg == WAIT) && (cnt_reg == '0) && op_write_reg;

    // Storage is plain registers so an asynchronous reset can clear every word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [N-1:0] word_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (mem_we && (idx_reg == IW'(gi))) begin
                    word_reg <= wdata_reg;
                end
            end

            assign mem_rd[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_write_reg  <= 1'b0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            read_data_reg <= '0;
            mem_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (legal) begin
                            state_reg    <= WAIT;
                            cnt_reg      <= CW'(LATENCY - 1);
                            op_write_reg <= memWrite;
                            idx_reg      <= address[IW+2:3];
                            wdata_reg    <= writeData;
                        end else begin
                            state_reg     <= DONE;
                            mem_error_reg <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else begin
                        // Store completes on this same edge via mem_we.
                        if (!op_write_reg) begin
                            read_data_reg <= mem_rd[idx_reg];
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    mem_error_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Stall is raised in the same cycle a request appears in IDLE.
    assign memBusy  = (state_reg == WAIT) || ((state_reg == IDLE) && req);
    assign readData = read_data_reg;
    assign memError = mem_error_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random accesses checked against
// an array-based model of the memory and its legality/latency rules.
module tb_dmem_ctrl;

    localparam int N       = 64;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         memRead;
    logic         memWrite;
    logic [N-1:0] address;
    logic [N-1:0] writeData;
    logic [N-1:0] readData;
    logic         memBusy;
    logic         memError;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [N-1:0] model_mem [DEPTH];
    logic [N-1:0] model_rd;

    dmem_ctrl #(.N(N), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .memBusy   (memBusy),
        .memError  (memError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = '0;
    endtask

    // One access from IDLE to the IDLE cycle after DONE, checked against the model.
    task automatic txn(input logic rd, input logic wr, input logic [N-1:0] addr,
                       input logic [N-1:0] data, input bit scramble);
        logic legal;
        int   busy_cycles;
        int   exp_cycles;
        int   idx;
        legal = (rd ^ wr) && (addr[2:0] == 3'b000) && (addr[63:3] < DEPTH);
        idx   = legal ? int'(addr[8:3]) : 0;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; address = addr; writeData = data;
        busy_cycles = 0;
        @(negedge clk);
        while (memBusy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            @(posedge clk); #1;
            if (scramble) begin
                memRead   = 1'($urandom);
                memWrite  = 1'($urandom);
                address   = {$urandom, $urandom};
                writeData = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        if (legal && rd) model_rd = model_mem[idx];
        if (legal && wr) model_mem[idx] = data;
        exp_cycles = legal ? LATENCY + 1 : 1;
        $display("txn rd=%0b wr=%0b addr=0x%0h data=0x%0h busy=%0d err=%0b rdata=0x%0h",
                 rd, wr, addr, data, busy_cycles, memError, readData);
        check("busy_cycles", N'(busy_cycles), N'(exp_cycles));
        check("done_error", N'(memError), N'(!legal));
        check("done_readData", readData, model_rd);
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
        check("idle_busy", N'(memBusy), '0);
        check("idle_error", N'(memError), '0);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] d;
        logic         r;
        logic         w;
        int           kind;

        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0;
        model_reset();
        #1;
        check("reset_readData", readData, '0);
        check("reset_busy", N'(memBusy), '0);
        check("reset_error", N'(memError), '0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF, 1'b0);
        txn(1'b1, 1'b0, 64'h10, 64'h0, 1'b0);
        txn(1'b1, 1'b0, 64'h18, 64'h0, 1'b0);
        txn(1'b0, 1'b1, 64'h30, 64'hCAFE, 1'b0);
        txn(1'b1, 1'b0, 64'h30, 64'h0, 1'b0);
        txn(1'b1, 1'b0, 64'h13, 64'h0, 1'b0);
        txn(1'b1, 1'b0, 64'h200, 64'h0, 1'b0);
        txn(1'b0, 1'b1, 64'h1F8, 64'h0123456789ABCDEF, 1'b0);
        txn(1'b1, 1'b0, 64'h1F8, 64'h0, 1'b0);
        txn(1'b1, 1'b1, 64'h0, 64'hFFFF, 1'b0);
        txn(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        txn(1'b0, 1'b1, 64'h28, 64'h77, 1'b1);
        txn(1'b1, 1'b0, 64'h28, 64'h0, 1'b1);

        // Reset pulsed while a store is waiting.
        @(posedge clk); #1;
        memWrite = 1'b1; address = 64'h20; writeData = 64'h55;
        @(posedge clk); #1;
        memWrite = 1'b0;
        check("wait_busy", N'(memBusy), N'(1));
        reset = 1'b1;
        #1;
        model_reset();
        $display("reset mid-WAIT busy=%0b err=%0b rdata=0x%0h", memBusy, memError, readData);
        check("rst_busy", N'(memBusy), '0);
        check("rst_error", N'(memError), '0);
        check("rst_readData", readData, '0);
        @(negedge clk); reset = 1'b0;
        txn(1'b1, 1'b0, 64'h20, 64'h0, 1'b0);
        txn(1'b1, 1'b0, 64'h28, 64'h0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                7:       a = {$urandom, $urandom};
                8:       a = {55'($urandom), 9'h0} | 64'h1;
                9:       a = ($urandom_range(0, 1) == 1) ? 64'h1F8 : 64'h200;
                default: a = {52'h0, 6'($urandom), 3'b000};
            endcase
            if (kind == 6) a[2:0] = 3'($urandom_range(1, 7));
            d = {$urandom, $urandom};
            w = ($urandom_range(0, 1) == 1);
            r = !w;
            if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
            txn(r, w, a, d, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory stage that consumes the 64-bit ALU result as a byte address and executes LDUR/STUR accesses against a word-organized memory with a fixed multi-cycle access latency. It sits directly downstream of the `alu`: `address` is the ALU `result`, and `writeData` is the register-file second read operand. It raises `memBusy` so the single-cycle datapath holds its PC and control until the access completes. It flags illegal accesses instead of performing them.

## Interface
- `N`, 64: data and address width.
- `DEPTH`, 64: number of 64-bit words; valid word index 0..DEPTH-1.
- `LATENCY`, 2: cycles spent in WAIT per access. Legal range is ≥1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state and memory contents immediately.
- `memRead` in 1: load request.
- `memWrite` in 1: store request.
- `address` in N: byte address (ALU result).
- `writeData` in N: store data.
- `readData` out N: last completed load value. Reset value 0.
- `memBusy` out 1: stall request to the datapath. Reset value 0.
- `memError` out 1: illegal-access flag, valid in DONE. Reset value 0.

## Operation
- Word index = `address[N-1:3]`.
- A request is legal when all of the following hold:
  - exactly one of `memRead`/`memWrite` is high;
  - `address[2:0]==0`;
  - index < DEPTH.
- On entry to WAIT, the block latches operation, index and `writeData`. Inputs that change after that point are ignored until the block returns to IDLE.
- The FSM has three states: IDLE, WAIT, DONE. It resets to IDLE.
- **IDLE**, no request (`memRead|memWrite` = 0): `memBusy`=0, remain in IDLE.
- **IDLE**, any request: `memBusy`=1 combinationally in the same cycle.
  - Legal request: next state is WAIT, counter is loaded with LATENCY-1.
  - Illegal request: next state is DONE, `memError` register set to 1. No memory access takes place.
- **WAIT**: `memBusy`=1.
  - At each edge with counter≠0, decrement the counter.
  - At the edge with counter==0, perform the access and go to DONE:
    - read: `readData` ← mem[index];
    - write: mem[index] ← latched data.
- **DONE**: `memBusy`=0, so the datapath advances on this edge. `readData` and `memError` are held. Next state is IDLE and `memError` clears to 0.
- `readData` changes only on a completed legal read. Stores and errors leave it unchanged.
- Memory contents reset to all zeros.

## Timing
- For a legal request first seen in IDLE at cycle 0:
  - `memBusy` is high in cycles 0..LATENCY;
  - DONE occurs in cycle LATENCY+1 (cycle 3 for LATENCY=2);
  - `readData` becomes valid at the start of DONE.
- Illegal request: `memBusy` is high in cycle 0 only, DONE (with `memError`=1) in cycle 1.
- After DONE there is always at least one IDLE cycle. A request present in that IDLE cycle starts a new access there; there is no back-to-back acceptance from DONE.
- A load from a word written by the immediately preceding store returns the new data, because the write completes before DONE.
- Reset asserted mid-WAIT:
  - the state returns to IDLE and all outputs go to 0 immediately;
  - the pending store is discarded, not partially written;
  - memory is cleared.
- `memWrite`/`memRead` deasserting during WAIT does not abort the access.

## Test plan
- Reset, then STUR with address=0x10 and writeData=0xDEADBEEF, followed by LDUR with address=0x10 → `memBusy` is high for 3 cycles per access, and `readData`=0xDEADBEEF in the second DONE.
- LDUR with address=0x18 from reset → `readData`=0 and `memError`=0. `readData` keeps its previous value across a subsequent store.
- LDUR with address=0x13 (misaligned) → `memBusy` is high for 1 cycle, `memError`=1 for one cycle, `readData` unchanged.
- LDUR with address=8·64=0x200 (index = DEPTH) → `memError`=1 with no access. Address 0x1F8 (index 63) succeeds.
- `memRead`=`memWrite`=1 with address=0x0 → `memError`=1, and a following load from 0x0 shows memory unmodified.
- STUR with address=0x20 and data=0x55, with reset pulsed during WAIT → outputs go to 0 at once, and a following LDUR from 0x20 returns 0.
